// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-stage request/response and memory-port signals of the shared memory arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  stall_if;
  logic                  stall_mem;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between the IF and MEM pipeline stages
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  last_mem_q;
  logic                  store_q;
  logic                  if_elig;
  logic                  mem_elig;
  logic                  grant_mem;
  logic                  grant_if;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] rdata;
  assign if_elig    = bus.if_req & ~bus.if_done;
  assign mem_elig   = bus.mem_req & ~bus.mem_done;
  assign grant_mem  = mem_elig & ~(if_elig & last_mem_q);
  assign grant_if   = if_elig & ~grant_mem;
  assign grant_addr = grant_mem ? bus.mem_addr : bus.if_addr;
  assign rdata      = bus.ram_rdata;
  assign bus.stall_if  = bus.if_req & ~bus.if_done;
  assign bus.stall_mem = bus.mem_req & ~bus.mem_done;
  // Grant in IDLE, hold the counter during the strobe cycle, then count down and capture read data on the last count.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_mem_q    <= 1'b0;
      store_q       <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
    end else begin
      bus.ram_en   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      if (state_q == IDLE) begin
        if (grant_mem | grant_if) begin
          bus.ram_en    <= 1'b1;
          bus.ram_we    <= grant_mem & bus.mem_we;
          bus.ram_addr  <= grant_addr;
          bus.ram_wdata <= bus.mem_wdata;
          store_q       <= grant_mem & bus.mem_we;
          cnt_q         <= 4'(MEM_LATENCY);
          last_mem_q    <= grant_mem;
          state_q       <= grant_mem ? BUSY_MEM : BUSY_IF;
        end
      end else if (!bus.ram_en && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_q <= IDLE;
          if (state_q == BUSY_IF) begin
            bus.if_rdata <= rdata;
            bus.if_done  <= 1'b1;
          end else begin
            if (!store_q) bus.mem_rdata <= rdata;
            bus.mem_done <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven cycle checks of the arbiter at latency 2 plus a latency-1 load sequence
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int row = -1;
  localparam logic [31:0] DA = 32'h2402000A, DC = 32'hCAFE0080, DD = 32'hDEADBEEF;
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(b));
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h40 ? DA : a == 32'h80 ? DC : 32'h11110000 ^ a;
  endfunction
  logic        p0 = 1'b0, p1 = 1'b0, st_valid = 1'b0, v1 = 1'b0;
  logic [31:0] q0 = '0, q1 = '0, st_addr = '0, st_data = '0;
  always @(posedge clk) begin
    p0 <= b.ram_en;
    p1 <= p0;
    q0 <= b.ram_addr;
    q1 <= q0;
    v1 <= b1.ram_en;
    if (b.ram_en && b.ram_we) begin
      st_valid <= 1'b1;
      st_addr  <= b.ram_addr;
      st_data  <= b.ram_wdata;
    end
  end
  assign b.ram_rdata  = !p1 ? 32'hBAD0BAD0 : (st_valid && q1 == st_addr) ? st_data : rom(q1);
  assign b1.ram_rdata = v1 ? 32'h13572468 : 32'hBAD0BAD0;
  typedef struct {
    logic rs, ir; logic [31:0] ia; logic mr, mw; logic [31:0] ma, md;
    logic en, we; logic [31:0] ra; logic idn, mdn; logic [31:0] ird, mrd;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(input logic rs, ir, input logic [31:0] ia, input logic mr, mw,
                             input logic [31:0] ma, md, input logic en, we, input logic [31:0] ra,
                             input logic idn, mdn, input logic [31:0] ird, mrd);
    vec_t t;
    t.rs = rs; t.ir = ir; t.ia = ia; t.mr = mr; t.mw = mw; t.ma = ma; t.md = md;
    t.en = en; t.we = we; t.ra = ra; t.idn = idn; t.mdn = mdn; t.ird = ird; t.mrd = mrd;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", n, row, act, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    {b.if_req, b.mem_req, b.mem_we} = '0;
    {b.if_addr, b.mem_addr, b.mem_wdata} = '0;
    {b1.if_req, b1.mem_req, b1.mem_we} = '0;
    {b1.if_addr, b1.mem_addr, b1.mem_wdata} = '0;
    // single fetch 0x40, held through done, re-issued, then dropped during busy
    tv.push_back(v(0,1,'h40,0,0,0,0,       0,0,0,0,0,0,0));
    tv.push_back(v(0,1,'h40,0,0,0,0,       1,0,'h40,0,0,0,0));
    tv.push_back(v(0,1,'h40,0,0,0,0,       0,0,'h40,0,0,0,0));
    tv.push_back(v(0,1,'h40,0,0,0,0,       0,0,'h40,0,0,0,0));
    tv.push_back(v(0,1,'h40,0,0,0,0,       0,0,'h40,1,0,DA,0));
    tv.push_back(v(0,1,'h40,0,0,0,0,       0,0,'h40,0,0,DA,0));
    tv.push_back(v(0,0,'h40,0,0,0,0,       1,0,'h40,0,0,DA,0));
    tv.push_back(v(0,0,'h40,0,0,0,0,       0,0,'h40,0,0,DA,0));
    tv.push_back(v(0,0,'h40,0,0,0,0,       0,0,'h40,0,0,DA,0));
    tv.push_back(v(0,0,'h40,0,0,0,0,       0,0,'h40,1,0,DA,0));
    // store 0xDEADBEEF to 0x100
    tv.push_back(v(0,0,0,1,1,'h100,DD,     0,0,'h40,0,0,DA,0));
    tv.push_back(v(0,0,0,1,1,'h100,DD,     1,1,'h100,0,0,DA,0));
    tv.push_back(v(0,0,0,1,1,'h100,DD,     0,0,'h100,0,0,DA,0));
    tv.push_back(v(0,0,0,1,1,'h100,DD,     0,0,'h100,0,0,DA,0));
    tv.push_back(v(0,0,0,1,1,'h100,DD,     0,0,'h100,0,1,DA,0));
    // reset, then simultaneous IF 0x80 and MEM load 0x100
    tv.push_back(v(1,0,0,0,0,0,0,          0,0,0,0,0,0,0));
    tv.push_back(v(0,1,'h80,1,0,'h100,0,   0,0,0,0,0,0,0));
    tv.push_back(v(0,1,'h80,1,0,'h100,0,   1,0,'h100,0,0,0,0));
    tv.push_back(v(0,1,'h80,1,0,'h100,0,   0,0,'h100,0,0,0,0));
    tv.push_back(v(0,1,'h80,1,0,'h100,0,   0,0,'h100,0,0,0,0));
    tv.push_back(v(0,1,'h80,1,0,'h100,0,   0,0,'h100,0,1,0,DD));
    tv.push_back(v(0,1,'h80,0,0,0,0,       1,0,'h80,0,0,0,DD));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,0,0,0,DD));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,0,0,0,DD));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,1,0,DC,DD));
    // MEM-only load 0x40, then a tie with last grant to MEM: IF must win
    tv.push_back(v(0,0,0,1,0,'h40,0,       0,0,'h80,0,0,DC,DD));
    tv.push_back(v(0,0,0,1,0,'h40,0,       1,0,'h40,0,0,DC,DD));
    tv.push_back(v(0,0,0,1,0,'h40,0,       0,0,'h40,0,0,DC,DD));
    tv.push_back(v(0,0,0,1,0,'h40,0,       0,0,'h40,0,0,DC,DD));
    tv.push_back(v(0,0,0,1,0,'h40,0,       0,0,'h40,0,1,DC,DA));
    tv.push_back(v(0,1,'h40,1,0,'h100,0,   0,0,'h40,0,0,DC,DA));
    tv.push_back(v(0,1,'h40,1,0,'h100,0,   1,0,'h40,0,0,DC,DA));
    tv.push_back(v(0,1,'h40,1,0,'h100,0,   0,0,'h40,0,0,DC,DA));
    tv.push_back(v(0,1,'h40,1,0,'h100,0,   0,0,'h40,0,0,DC,DA));
    tv.push_back(v(0,1,'h40,1,0,'h100,0,   0,0,'h40,1,0,DA,DA));
    tv.push_back(v(0,0,0,1,0,'h100,0,      1,0,'h100,0,0,DA,DA));
    tv.push_back(v(0,0,0,1,0,'h100,0,      0,0,'h100,0,0,DA,DA));
    tv.push_back(v(0,0,0,1,0,'h100,0,      0,0,'h100,0,0,DA,DA));
    tv.push_back(v(0,0,0,1,0,'h100,0,      0,0,'h100,0,1,DA,DD));
    tv.push_back(v(0,0,0,0,0,0,0,          0,0,'h100,0,0,DA,DD));
    // fetch 0x80 aborted by reset in its second cycle, then re-arbitrated
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h100,0,0,DA,DD));
    tv.push_back(v(0,1,'h80,0,0,0,0,       1,0,'h80,0,0,DA,DD));
    tv.push_back(v(1,1,'h80,0,0,0,0,       0,0,0,0,0,0,0));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,0,0,0,0,0));
    tv.push_back(v(0,1,'h80,0,0,0,0,       1,0,'h80,0,0,0,0));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,0,0,0,0));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,0,0,0,0));
    tv.push_back(v(0,1,'h80,0,0,0,0,       0,0,'h80,1,0,DC,0));
    tv.push_back(v(0,0,0,0,0,0,0,          0,0,'h80,0,0,DC,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(b.ram_en), 0);
    chk("rst_ram_we", 32'(b.ram_we), 0);
    chk("rst_ram_addr", b.ram_addr, 0);
    chk("rst_ram_wdata", b.ram_wdata, 0);
    chk("rst_if_rdata", b.if_rdata, 0);
    chk("rst_mem_rdata", b.mem_rdata, 0);
    chk("rst_if_done", 32'(b.if_done), 0);
    chk("rst_mem_done", 32'(b.mem_done), 0);
    chk("rst_l1_ram_en", 32'(b1.ram_en), 0);
    foreach (tv[i]) begin
      row = i;
      @(posedge clk);
      #1;
      reset       = tv[i].rs;
      b.if_req    = tv[i].ir;
      b.if_addr   = tv[i].ia;
      b.mem_req   = tv[i].mr;
      b.mem_we    = tv[i].mw;
      b.mem_addr  = tv[i].ma;
      b.mem_wdata = tv[i].md;
      @(negedge clk);
      chk("ram_en", 32'(b.ram_en), 32'(tv[i].en));
      if (tv[i].en) chk("ram_we", 32'(b.ram_we), 32'(tv[i].we));
      chk("ram_addr", b.ram_addr, tv[i].ra);
      chk("if_done", 32'(b.if_done), 32'(tv[i].idn));
      chk("mem_done", 32'(b.mem_done), 32'(tv[i].mdn));
      chk("if_rdata", b.if_rdata, tv[i].ird);
      chk("mem_rdata", b.mem_rdata, tv[i].mrd);
      chk("stall_if", 32'(b.stall_if), 32'(tv[i].ir & ~tv[i].idn));
      chk("stall_mem", 32'(b.stall_mem), 32'(tv[i].mr & ~tv[i].mdn));
    end
    // latency-1 load: strobe in cycle 1, done in cycle 3
    row = 1000;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    b1.mem_req = 1'b1;
    b1.mem_addr = 32'h200;
    for (int c = 0; c < 6; c++) begin
      row = 1000 + c;
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 4) b1.mem_req = 1'b0;
      @(negedge clk);
      chk("l1_ram_en", 32'(b1.ram_en), 32'(c == 1));
      chk("l1_mem_done", 32'(b1.mem_done), 32'(c == 3));
      chk("l1_stall_mem", 32'(b1.stall_mem), 32'(c < 3));
    end
    chk("l1_mem_rdata", b1.mem_rdata, 32'h13572468);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch stage and the memory stage of the pipelined MIPS core. It grants one access at a time, drives the memory port, counts out the access latency, and returns read data to the winning stage. It raises per-stage stall signals that freeze the IF and MEM pipeline registers until each stage's access completes.

## Interface
- `ADDR_WIDTH`, 32: width of the address buses.
- `DATA_WIDTH`, 32: width of the data buses.
- `MEM_LATENCY`, 2: cycles from the `ram_en` cycle to the cycle in which `ram_rdata` is valid. Legal range is 1..15.

- `clk` in 1: single clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held stable until `if_done`.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_done` out 1: one-cycle pulse. Fetch complete; `if_rdata` is valid.
- `if_rdata` out DATA_WIDTH: fetched word. Registered.
- `mem_req` in 1: load/store request. Held stable until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in ADDR_WIDTH: load/store address.
- `mem_wdata` in DATA_WIDTH: store data.
- `mem_done` out 1: one-cycle pulse. Access complete.
- `mem_rdata` out DATA_WIDTH: load data. Registered.
- `stall_if` out 1: `if_req & ~if_done`. Combinational.
- `stall_mem` out 1: `mem_req & ~mem_done`. Combinational.
- `ram_en` out 1: one-cycle access strobe. Registered.
- `ram_we` out 1: write enable. Qualified by `ram_en`.
- `ram_addr` out ADDR_WIDTH: memory address. Registered.
- `ram_wdata` out DATA_WIDTH: memory write data. Registered.
- `ram_rdata` in DATA_WIDTH: memory read data. Valid MEM_LATENCY cycles after `ram_en`.

## Operation
- **FSM states:** IDLE, BUSY_IF, BUSY_MEM. There is a 4-bit down-counter `cnt` and a 1-bit `last_mem` flag (the last grant went to MEM).
- **Arbitration in IDLE, per cycle:**
  - Eligible requesters exclude any requester whose done pulse is high in that cycle. This prevents a re-issue while the completed request is still asserted.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant MEM, unless `last_mem`=1, in which case grant IF. This alternates grants and prevents IF starvation.
- **Grant action (at the clock edge):**
  - Register address and wdata into `ram_addr`/`ram_wdata`.
  - `ram_we` = `mem_we` for a MEM grant, 0 for an IF grant.
  - `ram_en` = 1 for exactly the next cycle.
  - `cnt` = MEM_LATENCY.
  - Go to BUSY_IF or BUSY_MEM, and update `last_mem`.
- **BUSY_x:**
  - `cnt` decrements each cycle while it is nonzero.
  - On the edge where `cnt`=1, capture `ram_rdata` into `x_rdata`. For a store, `mem_rdata` holds its previous value.
  - On that same edge, pulse `x_done` for the next cycle and return to IDLE.
- **Handshake rules:**
  - A stage holds req/addr/we/wdata stable while its stall is high.
  - In the done cycle the stall drops and the pipeline register advances.
  - Requests are sampled only in IDLE. Input changes during BUSY are ignored.
- **Address/data widths:** no arithmetic on addresses. Values pass through unchanged at full width.

## Timing
- **Reset values** (all outputs, asynchronous): `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `if_rdata`=0, `mem_rdata`=0, `if_done`=0, `mem_done`=0. Also state=IDLE, `cnt`=0, `last_mem`=0. The stalls follow the requests combinationally.
- **Access timeline:** request seen in IDLE in cycle 0 → `ram_en` in cycle 1 → `ram_rdata` valid in cycle 1+L → `x_done` and `x_rdata` in cycle 2+L.
  - Stall is high in cycles 0..1+L, giving a total occupancy of L+2 cycles.
  - Back-to-back throughput is one access per L+2 cycles.
- **Second requester waiting:** it is granted in the done cycle of the first (IDLE, not masked). Its `ram_en` falls in cycle 3+L.
- **Both requests arriving in the same cycle:** exactly one grant. The loser's stall stays high throughout.
- **Reset asserted mid-access:** the in-flight access is abandoned and no done pulse is issued. After reset deasserts, requests still held are re-arbitrated from IDLE.
- **Request dropped during BUSY:** the access still completes and done still pulses. The requester must ignore it; this is illegal usage, but the FSM must not hang.

## Test plan
- **Single fetch, L=2:** `if_req`=1, `if_addr`=0x40, memory returns 0x2402000A. Expect `ram_en` in cycle 1 with `ram_addr`=0x40, `if_done` and `if_rdata`=0x2402000A in cycle 4, `stall_if` high in cycles 0..3.
- **Store:** `mem_req`=1, `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF. Expect `ram_en`=`ram_we`=1 in cycle 1, `mem_done` in cycle 4, `mem_rdata` unchanged.
- **Simultaneous IF+MEM load from reset:** expect MEM granted first (done cycle 4). IF `ram_en` in cycle 5, `if_done` in cycle 8. With both still requesting next time, IF wins the following tie.
- **Reset mid-access:** assert `reset` in cycle 2 of a fetch. Expect all outputs 0 immediately and no `if_done`. After release with `if_req` held, a fresh `ram_en` occurs one cycle later.
- **Done masking:** keep `if_req` high through `if_done`. Expect no re-issue in the done cycle; a new `ram_en` occurs in the following cycle only if `if_req` is still high.
- **MEM_LATENCY=1:** single load. Expect `mem_done` in cycle 3.
